apb_master_arbiter: RTL and testbench

APB_MASTER_ARBITER -- requirements
Module: apb_master_arbiter

---
 rtl/apb_master_arbiter.sv | 148 ++++++++++++++
 tb/tb_apb_master_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_arbiter.sv
// rtl/apb_master_arbiter.sv - APB master shared by two requesters via round-robin arbitration
module apb_master_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [1:0]              req_write,
  input  logic [63:0]             req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    busy,
  output logic [31:0]             PADDR,
  output logic                    PWRITE,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic [DATA_WIDTH-1:0]   PDATA_O,
  output logic                    PDATA_OE,
  input  logic [DATA_WIDTH-1:0]   PDATA_I,
  input  logic                    PREADY
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  // Last ACCESS cycle index before a stalled transfer is abandoned.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t                  state_q, state_d;
  logic                    last_grant_q;
  logic                    gnt_q;
  logic [31:0]             paddr_q;
  logic                    pwrite_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [7:0]              cnt_q;
  logic [1:0]              rsp_valid_q;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;
  logic                    rsp_err_q;

  logic                    grant;
  logic                    accept;
  logic                    done;
  logic                    abort;

  // Round-robin pick: a lone requester wins; on contention the one not served last wins.
  always_comb begin
    grant = 1'b0;
    case (req_valid)
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_grant_q;
      default: grant = 1'b0;
    endcase
    accept    = (state_q == IDLE) && (|req_valid);
    req_ready = accept ? (grant ? 2'b10 : 2'b01) : 2'b00;
  end

  // Next-state logic; completion on PREADY wins over the timeout in the same cycle.
  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    abort   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) state_d = SETUP;
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          done    = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          abort   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge PCLK) begin
    if (PRESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Request capture, grant history, timeout counter and registered response.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      paddr_q      <= '0;
      pwrite_q     <= 1'b0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      rsp_valid_q  <= 2'b00;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      rsp_valid_q <= 2'b00;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;

      if (accept) begin
        gnt_q        <= grant;
        last_grant_q <= grant;
        paddr_q      <= grant ? req_addr[63:32] : req_addr[31:0];
        pwrite_q     <= grant ? req_write[1] : req_write[0];
        wdata_q      <= grant ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                              : req_wdata[DATA_WIDTH-1:0];
      end

      if (state_q == SETUP) begin
        cnt_q <= '0;
      end else if ((state_q == ACCESS) && !PREADY) begin
        cnt_q <= cnt_q + 8'd1;
      end

      if (done) begin
        rsp_valid_q <= {gnt_q, ~gnt_q};
        rsp_rdata_q <= pwrite_q ? '0 : PDATA_I;
      end else if (abort) begin
        rsp_valid_q <= {gnt_q, ~gnt_q};
        rsp_err_q   <= 1'b1;
      end
    end
  end

  assign busy      = (state_q != IDLE);
  assign PSEL      = (state_q != IDLE);
  assign PENABLE   = (state_q == ACCESS);
  assign PADDR     = paddr_q;
  assign PWRITE    = pwrite_q;
  assign PDATA_OE  = pwrite_q && (state_q != IDLE);
  assign PDATA_O   = PDATA_OE ? wdata_q : '0;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb/tb_apb_master_arbiter.sv - directed self-checking bench for apb_master_arbiter
module tb_apb_master_arbiter;

  logic        PCLK;
  logic        PRESET;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic [31:0] PADDR;
  logic        PWRITE;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PDATA_O;
  logic        PDATA_OE;
  logic [31:0] PDATA_I;
  logic        PREADY;

  int n_cmp = 0;
  int n_err = 0;

  apb_master_arbiter #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .PADDR     (PADDR),
    .PWRITE    (PWRITE),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PDATA_O   (PDATA_O),
    .PDATA_OE  (PDATA_OE),
    .PDATA_I   (PDATA_I),
    .PREADY    (PREADY)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic tick;
    @(posedge PCLK);
    #2;
  endtask

  // Let combinational outputs settle before sampling.
  task automatic settle;
    #1;
  endtask

  initial begin
    PRESET    = 1'b1;
    req_valid = 2'b00;
    req_write = 2'b00;
    req_addr  = '0;
    req_wdata = '0;
    PDATA_I   = '0;
    PREADY    = 1'b0;

    // Reset state
    tick; tick; settle;
    chk("rst_psel",     PSEL,      1'b0);
    chk("rst_penable",  PENABLE,   1'b0);
    chk("rst_paddr",    PADDR,     32'h0);
    chk("rst_pwrite",   PWRITE,    1'b0);
    chk("rst_pdata_oe", PDATA_OE,  1'b0);
    chk("rst_pdata_o",  PDATA_O,   32'h0);
    chk("rst_busy",     busy,      1'b0);
    chk("rst_rsp_v",    rsp_valid, 2'b00);
    chk("rst_ready",    req_ready, 2'b00);
    PRESET = 1'b0;
    tick;

    // Single read from requester 0 with immediate PREADY
    req_valid = 2'b01; req_write = 2'b00; req_addr = 64'h0000_0000_0000_0010;
    PREADY = 1'b1; PDATA_I = 32'hDEAD_BEEF;
    settle;
    chk("rd_ready_T", req_ready, 2'b01);
    chk("rd_psel_T",  PSEL,      1'b0);
    tick; req_valid = 2'b00; settle;
    chk("rd_psel_T1",    PSEL,    1'b1);
    chk("rd_penable_T1", PENABLE, 1'b0);
    chk("rd_paddr_T1",   PADDR,   32'h10);
    chk("rd_pwrite_T1",  PWRITE,  1'b0);
    chk("rd_oe_T1",      PDATA_OE, 1'b0);
    chk("rd_busy_T1",    busy,    1'b1);
    tick; settle;
    chk("rd_psel_T2",    PSEL,    1'b1);
    chk("rd_penable_T2", PENABLE, 1'b1);
    chk("rd_rspv_T2",    rsp_valid, 2'b00);
    tick; settle;
    chk("rd_rspv_T3",  rsp_valid, 2'b01);
    chk("rd_rdata_T3", rsp_rdata, 32'hDEAD_BEEF);
    chk("rd_err_T3",   rsp_err,   1'b0);
    chk("rd_psel_T3",  PSEL,      1'b0);
    chk("rd_busy_T3",  busy,      1'b0);
    tick; settle;
    chk("rd_rspv_T4",  rsp_valid, 2'b00);
    chk("rd_paddr_hold", PADDR,   32'h10);

    // Write from requester 1 with three wait states
    req_valid = 2'b10; req_write = 2'b10; req_addr = 64'h0000_0020_0000_0000;
    req_wdata = 64'h0000_0055_0000_0000; PREADY = 1'b0;
    settle;
    chk("wr_ready", req_ready, 2'b10);
    tick; req_valid = 2'b00; settle;
    chk("wr_setup_oe",    PDATA_OE, 1'b1);
    chk("wr_setup_pdata", PDATA_O,  32'h55);
    chk("wr_setup_paddr", PADDR,    32'h20);
    chk("wr_setup_pwr",   PWRITE,   1'b1);
    for (int i = 0; i < 4; i++) begin
      tick;
      PREADY = (i == 3);
      settle;
      chk("wr_acc_penable", PENABLE,   1'b1);
      chk("wr_acc_oe",      PDATA_OE,  1'b1);
      chk("wr_acc_pdata",   PDATA_O,   32'h55);
      chk("wr_acc_rspv",    rsp_valid, 2'b00);
    end
    tick; settle;
    chk("wr_rspv",  rsp_valid, 2'b10);
    chk("wr_rdata", rsp_rdata, 32'h0);
    chk("wr_err",   rsp_err,   1'b0);
    chk("wr_oe_idle", PDATA_OE, 1'b0);

    // Contention: both requesters valid, grants alternate starting at 0
    req_valid = 2'b11; req_write = 2'b00; req_addr = 64'h0000_0200_0000_0100;
    PREADY = 1'b1; PDATA_I = 32'hA5A5_0000;
    settle;
    for (int k = 0; k < 4; k++) begin
      chk("rr_ready", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      tick;
      if (k == 3) req_valid = 2'b00;
      settle;
      chk("rr_paddr",     PADDR,     (k % 2 == 0) ? 32'h100 : 32'h200);
      chk("rr_ready_set", req_ready, 2'b00);
      tick; settle;
      chk("rr_penable", PENABLE, 1'b1);
      tick; settle;
      chk("rr_rspv",  rsp_valid, (k % 2 == 0) ? 2'b01 : 2'b10);
      chk("rr_rdata", rsp_rdata, 32'hA5A5_0000);
    end
    chk("rr_ready_end", req_ready, 2'b00);

    // Timeout: PREADY never rises
    tick;
    req_valid = 2'b01; req_write = 2'b00; req_addr = 64'h0000_0000_0000_0040;
    PREADY = 1'b0; PDATA_I = 32'hFFFF_FFFF;
    settle;
    chk("to_ready", req_ready, 2'b01);
    tick; req_valid = 2'b00; settle;
    for (int i = 0; i < 16; i++) begin
      tick; settle;
      chk("to_acc_penable", PENABLE,   1'b1);
      chk("to_acc_rspv",    rsp_valid, 2'b00);
    end
    tick; settle;
    chk("to_psel",    PSEL,      1'b0);
    chk("to_penable", PENABLE,   1'b0);
    chk("to_rspv",    rsp_valid, 2'b01);
    chk("to_err",     rsp_err,   1'b1);
    chk("to_rdata",   rsp_rdata, 32'h0);

    // Timeout tie: PREADY rises in the 16th ACCESS cycle; stray requests ignored while busy
    tick;
    req_valid = 2'b10; req_write = 2'b00; req_addr = 64'h0000_0050_0000_0000;
    PREADY = 1'b0; PDATA_I = 32'hCAFE_F00D;
    settle;
    chk("tie_ready", req_ready, 2'b10);
    tick; req_valid = 2'b00; settle;
    for (int i = 0; i < 16; i++) begin
      tick;
      PREADY    = (i == 15);
      req_valid = (i == 5) ? 2'b01 : 2'b00;
      settle;
      chk("tie_acc_penable", PENABLE,   1'b1);
      chk("tie_acc_ready",   req_ready, 2'b00);
    end
    tick; settle;
    chk("tie_rspv",  rsp_valid, 2'b10);
    chk("tie_err",   rsp_err,   1'b0);
    chk("tie_rdata", rsp_rdata, 32'hCAFE_F00D);
    tick; settle;
    chk("tie_no_latch_busy", busy, 1'b0);

    // Reset in the middle of ACCESS
    req_valid = 2'b01; req_write = 2'b01; req_addr = 64'h0000_0000_0000_0070;
    req_wdata = 64'h0000_0000_0000_0077; PREADY = 1'b0;
    settle;
    chk("mr_ready", req_ready, 2'b01);
    tick; req_valid = 2'b00;
    tick; settle;
    chk("mr_penable", PENABLE, 1'b1);
    PRESET = 1'b1;
    tick; settle;
    chk("mr_psel",    PSEL,      1'b0);
    chk("mr_penable0", PENABLE,  1'b0);
    chk("mr_paddr",   PADDR,     32'h0);
    chk("mr_pwrite",  PWRITE,    1'b0);
    chk("mr_oe",      PDATA_OE,  1'b0);
    chk("mr_pdata",   PDATA_O,   32'h0);
    chk("mr_busy",    busy,      1'b0);
    chk("mr_rspv",    rsp_valid, 2'b00);
    PRESET = 1'b0;
    tick; settle;
    chk("mr_rspv_after", rsp_valid, 2'b00);
    req_valid = 2'b11; req_write = 2'b00; req_addr = 64'h0000_0090_0000_0080;
    PREADY = 1'b1; PDATA_I = 32'h1234_5678;
    settle;
    chk("mr_first_grant", req_ready, 2'b01);
    tick; req_valid = 2'b00; settle;
    chk("mr_paddr_new", PADDR, 32'h80);
    tick; tick; settle;
    chk("mr_rspv_new",  rsp_valid, 2'b01);
    chk("mr_rdata_new", rsp_rdata, 32'h1234_5678);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
